// File: rtl/uart_apb_pkg.sv
// Shared types for the UART APB completer: transfer phases, access classes,
// register byte offsets and the address/direction classifier.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    ACC_REG,
    ACC_TX,
    ACC_RX,
    ACC_ERR
  } acc_class_e;

  localparam logic [4:0] CTRL_OFS   = 5'h00;
  localparam logic [4:0] STATUS_OFS = 5'h04;
  localparam logic [4:0] TXDATA_OFS = 5'h08;
  localparam logic [4:0] RXDATA_OFS = 5'h0C;
  localparam logic [4:0] BAUD_OFS   = 5'h10;

  // TX/RX bridging is only legal while the matching enable bit is set.
  function automatic acc_class_e classify(input logic [2:0] idx,
                                          input logic       wr,
                                          input logic [1:0] ctrl);
    acc_class_e cls;
    cls = ACC_ERR;
    case (idx)
      CTRL_OFS[4:2]:   cls = ACC_REG;
      BAUD_OFS[4:2]:   cls = ACC_REG;
      STATUS_OFS[4:2]: cls = wr ? ACC_ERR : ACC_REG;
      TXDATA_OFS[4:2]: cls = (wr && ctrl[0]) ? ACC_TX : ACC_ERR;
      RXDATA_OFS[4:2]: cls = (!wr && ctrl[1]) ? ACC_RX : ACC_ERR;
      default:         cls = ACC_ERR;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/apb_uart_regfile.sv
// CTRL/BAUD storage, sticky error flag and the register read mux.
// Reading STATUS clears the sticky flag unless an error is flagged the same cycle.
module apb_uart_regfile
  import uart_apb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              err_set,
  input  logic [2:0]        idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              tx_ready,
  input  logic              rx_valid,
  output logic [1:0]        ctrl,
  output logic [15:0]       baud_div,
  output logic [DATA_W-1:0] rdata
);

  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic        err_q, err_d;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:16];

  always_comb begin
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    err_d  = err_q;
    if (wr_en && idx == CTRL_OFS[4:2]) ctrl_d = wdata[1:0];
    if (wr_en && idx == BAUD_OFS[4:2]) baud_d = wdata[15:0];
    if (err_set)                                 err_d = 1'b1;
    else if (rd_en && idx == STATUS_OFS[4:2])    err_d = 1'b0;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      CTRL_OFS[4:2]:   rdata = DATA_W'(ctrl_q);
      STATUS_OFS[4:2]: rdata = DATA_W'({err_q, rx_valid, ~tx_ready});
      BAUD_OFS[4:2]:   rdata = DATA_W'(baud_q);
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 2'b00;
      baud_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      baud_q <= baud_d;
      err_q  <= err_d;
    end
  end

  assign ctrl     = ctrl_q;
  assign baud_div = baud_q;

endmodule

// File: rtl/apb_uart_completer.sv
// APB completer for the UART register file: transfer FSM plus TX/RX handshake bridge.
// Define APB_COMPLETER_TIMEOUT_EN to bound TXDATA/RXDATA wait states by TIMEOUT cycles.
module apb_uart_completer
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic [1:0]        ctrl,
  output logic [15:0]       baud_div,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  state_e             state_q, state_d, phase;
  acc_class_e         cls_q, cls_d, cls_now;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               rx_ready_q, rx_ready_d;
  logic               reg_wr, reg_rd, err_set, addr_bad, timeout_hit;
  logic [DATA_W-1:0]  reg_rdata;

  apb_uart_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .wr_en    (reg_wr),
    .rd_en    (reg_rd),
    .err_set  (err_set),
    .idx      (PADDR[4:2]),
    .wdata    (PWDATA),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .ctrl     (ctrl),
    .baud_div (baud_div),
    .rdata    (reg_rdata)
  );

  // Misaligned or out-of-window addresses never reach the register decode.
  assign addr_bad = (|PADDR[1:0]) | (|(PADDR >> 5));
  assign cls_now  = addr_bad ? ACC_ERR : classify(PADDR[4:2], PWRITE, ctrl);

`ifdef APB_COMPLETER_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ACCESS) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign timeout_hit = (wait_cnt_d == CNT_W'(TIMEOUT));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // SETUP is decoded from the bus in the cycle PSEL rises; it is never held in state_q.
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && PSEL && !PENABLE) phase = SETUP;

    state_d    = state_q;
    cls_d      = cls_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rx_ready_d = 1'b0;
    reg_wr     = 1'b0;
    reg_rd     = 1'b0;
    err_set    = 1'b0;

    case (phase)
      SETUP: begin
        state_d = ACCESS;
        cls_d   = cls_now;
        case (cls_now)
          ACC_REG: begin
            pready_d = 1'b1;
            reg_wr   = PWRITE;
            reg_rd   = !PWRITE;
            prdata_d = PWRITE ? '0 : reg_rdata;
          end
          ACC_TX: begin
            tx_valid_d = 1'b1;
            tx_data_d  = PWDATA[7:0];
          end
          ACC_RX: ;
          default: begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            err_set   = 1'b1;
          end
        endcase
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = IDLE;
        end else if (!PSEL) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end else if (cls_q == ACC_TX && tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          pready_d   = 1'b1;
        end else if (cls_q == ACC_RX && rx_valid) begin
          rx_ready_d = 1'b1;
          pready_d   = 1'b1;
          prdata_d   = DATA_W'(rx_data);
        end else if (timeout_hit) begin
          tx_valid_d = 1'b0;
          pready_d   = 1'b1;
          pslverr_d  = 1'b1;
          err_set    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cls_q      <= ACC_REG;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign PRDATA   = prdata_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_apb_uart_completer.sv
// Scoreboard bench for apb_uart_completer: the driver queues expected completions,
// a negedge monitor pops and compares them whenever PREADY is seen.
`timescale 1ns/1ps
module tb_apb_uart_completer;

`ifdef APB_COMPLETER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  ctrl;
  logic [15:0] baud_div;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  apb_uart_completer #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .ctrl(ctrl), .baud_div(baud_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, pready_cnt = 0, tx_cnt = 0, tx_bad = 0, rx_rdy_cnt = 0;
  logic [7:0]  exp_tx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: transfer cycle counter, handshake counters and scoreboard pops.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) cyc = 1;
      else if (PSEL)        cyc++;
      if (tx_valid) begin
        tx_cnt++;
        if (tx_data !== exp_tx) tx_bad++;
      end
      if (rx_ready) rx_rdy_cnt++;
      if (PREADY) begin
        pready_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected PREADY: got 1 with no transfer outstanding, expected 0");
        end else begin
          e = sb.pop_front();
          chk({e.name, " PRDATA"},  PRDATA, e.data);
          chk({e.name, " PSLVERR"}, {31'b0, PSLVERR}, {31'b0, e.err});
          chk({e.name, " latency"}, cyc, e.lat);
        end
      end
    end
  end

  task automatic apb_idle();
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic apb_start(input logic [4:0] a, input logic w, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
  endtask

  task automatic apb_xfer(input string name, input logic [4:0] a, input logic w,
                          input logic [31:0] d, input logic [31:0] xdata,
                          input logic xerr, input int xlat);
    exp_t e;
    e.name = name; e.data = xdata; e.err = xerr; e.lat = xlat;
    sb.push_back(e);
    apb_start(a, w, d);
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        @(posedge PCLK); #1;
        apb_idle();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s timeout: got no PREADY in 40 cycles, expected completion", name);
    void'(sb.pop_back());
    apb_idle();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " PREADY"},   {31'b0, PREADY}, 0);
    chk({tag, " PRDATA"},   PRDATA, 0);
    chk({tag, " PSLVERR"},  {31'b0, PSLVERR}, 0);
    chk({tag, " ctrl"},     {30'b0, ctrl}, 0);
    chk({tag, " baud_div"}, {16'b0, baud_div}, 0);
    chk({tag, " tx_data"},  {24'b0, tx_data}, 0);
    chk({tag, " tx_valid"}, {31'b0, tx_valid}, 0);
    chk({tag, " rx_ready"}, {31'b0, rx_ready}, 0);
  endtask

  initial begin
    int n;
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_reset_vals("reset");
    PRESETn = 1'b1;

    // Register writes and reads, zero wait
    apb_xfer("wr CTRL", 5'h00, 1, 32'h0000_0003, 32'h0, 0, 2);
    apb_xfer("rd CTRL", 5'h00, 0, 32'h0, 32'h0000_0003, 0, 2);
    chk("ctrl after write", {30'b0, ctrl}, 32'h3);
    apb_xfer("wr BAUD", 5'h10, 1, 32'h1234_ABCD, 32'h0, 0, 2);
    apb_xfer("rd BAUD", 5'h10, 0, 32'h0, 32'h0000_ABCD, 0, 2);
    chk("baud_div", {16'b0, baud_div}, 32'h0000_ABCD);
    apb_xfer("rd STATUS idle", 5'h04, 0, 32'h0, 32'h0000_0001, 0, 2);

    // TXDATA with tx_ready held low for three cycles
    apb_xfer("wr CTRL tx", 5'h00, 1, 32'h1, 32'h0, 0, 2);
    exp_tx = 8'hA5; tx_cnt = 0; tx_bad = 0;
    fork
      apb_xfer("wr TXDATA", 5'h08, 1, 32'h1234_56A5, 32'h0, 0, 6);
      begin
        repeat (5) @(posedge PCLK);
        #1 tx_ready = 1'b1;
        @(posedge PCLK);
        #1 tx_ready = 1'b0;
      end
    join
    chk("tx_valid cycles", tx_cnt, 4);
    chk("tx_data wrong cycles", tx_bad, 0);

    // RXDATA with rx_valid arriving two cycles into the wait
    apb_xfer("wr CTRL rx", 5'h00, 1, 32'h2, 32'h0, 0, 2);
    rx_rdy_cnt = 0;
    fork
      apb_xfer("rd RXDATA", 5'h0C, 0, 32'h0, 32'h0000_005C, 0, 5);
      begin
        repeat (4) @(posedge PCLK);
        #1 rx_valid = 1'b1; rx_data = 8'h5C;
      end
    join
    rx_valid = 1'b0; rx_data = 8'h00;
    chk("rx_ready pulses", rx_rdy_cnt, 1);

    // Error accesses and the sticky flag
    apb_xfer("rd 0x14", 5'h14, 0, 32'h0, 32'h0, 1, 2);
    apb_xfer("rd STATUS sticky", 5'h04, 0, 32'h0, 32'h0000_0005, 0, 2);
    apb_xfer("rd STATUS cleared", 5'h04, 0, 32'h0, 32'h0000_0001, 0, 2);
    apb_xfer("wr STATUS ro", 5'h04, 1, 32'hFFFF_FFFF, 32'h0, 1, 2);
    apb_xfer("rd TXDATA wo", 5'h08, 0, 32'h0, 32'h0, 1, 2);
    apb_xfer("wr CTRL misaligned", 5'h01, 1, 32'h3, 32'h0, 1, 2);
    chk("ctrl kept on errors", {30'b0, ctrl}, 32'h2);

    apb_xfer("wr CTRL off", 5'h00, 1, 32'h0, 32'h0, 0, 2);
    tx_cnt = 0;
    apb_xfer("wr TXDATA disabled", 5'h08, 1, 32'h0000_0011, 32'h0, 1, 2);
    chk("tx_valid when disabled", tx_cnt, 0);
    apb_xfer("rd RXDATA disabled", 5'h0C, 0, 32'h0, 32'h0, 1, 2);
    apb_xfer("rd STATUS after err", 5'h04, 0, 32'h0, 32'h0000_0005, 0, 2);

    // Access phase without setup is ignored
    n = pready_cnt;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 5'h00; PWDATA = 32'h3;
    repeat (3) @(posedge PCLK);
    #1 apb_idle();
    @(negedge PCLK);
    chk("missing setup PREADY count", pready_cnt, n);
    chk("missing setup ctrl", {30'b0, ctrl}, 32'h0);

    // PSEL dropped while waiting on the transmitter
    apb_xfer("wr CTRL tx2", 5'h00, 1, 32'h1, 32'h0, 0, 2);
    n = pready_cnt;
    apb_start(5'h08, 1, 32'h77);
    @(posedge PCLK); #1;
    apb_idle();
    @(negedge PCLK);
    @(negedge PCLK);
    chk("abort tx_valid", {31'b0, tx_valid}, 0);
    chk("abort PREADY count", pready_cnt, n);
    chk("abort ctrl", {30'b0, ctrl}, 32'h1);

`ifdef APB_COMPLETER_TIMEOUT_EN
    apb_xfer("wr CTRL tmo", 5'h00, 1, 32'h2, 32'h0, 0, 2);
    rx_rdy_cnt = 0;
    apb_xfer("rd RXDATA timeout", 5'h0C, 0, 32'h0, 32'h0, 1, 6);
    chk("timeout rx_ready", rx_rdy_cnt, 0);
    apb_xfer("rd STATUS timeout", 5'h04, 0, 32'h0, 32'h0000_0005, 0, 2);
`endif

    // Reset asserted while waiting on the receiver
    apb_xfer("wr CTRL rst", 5'h00, 1, 32'h2, 32'h0, 0, 2);
    rx_rdy_cnt = 0;
    apb_start(5'h0C, 0, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_reset_vals("mid-wait reset");
    @(posedge PCLK); #1;
    apb_idle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    chk("mid-wait reset rx_ready", rx_rdy_cnt, 0);
    apb_xfer("wr CTRL post", 5'h00, 1, 32'h2, 32'h0, 0, 2);
    apb_xfer("rd CTRL post", 5'h00, 0, 32'h0, 32'h0000_0002, 0, 2);

    repeat (3) @(posedge PCLK);
    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
